reg_write_ctrl: RTL and testbench
=================================

REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 Single clock clk; reset rst is synchronous and active-high; all state changes on posedge clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rename_valid / rename_ready  input / output  1 each  dispatch request to mark a register as pending.
REQ-005 rename_addr  input  REG_ADDR width (5)  destination architectural register.
REQ-006 rename_rob_id  input  ROB_ADDR width  ROB id of the producing instruction.
REQ-007 commit_valid / commit_ready  input / output  1 each  ROB commit request.
REQ-008 commit_addr  input  5  committed register; commit_rob_id  input  ROB_ADDR width  committed ROB id; commit_data  input  DATA_BUS width (32)  committed value.
REQ-009 flush_req  input  1  single-cycle pipeline flush pulse; flush_busy  output  1  high while the restore walk runs.
REQ-010 rf_write_en, rf_write_addr (5), rf_write_restore, rf_write_is_ref, rf_write_data (32)  outputs  drive the register file's single write port.

Function
REQ-011 The block arbitrates the single register-file write port with fixed priority flush > commit > rename, and keeps a 32-entry tracking table (valid bit plus ROB id per register) of the youngest pending rename.
REQ-012 States: IDLE, FIX, FLUSH; all rf_* outputs and ready signals are combinational functions of the current state, counter and inputs (zero-cycle latency).
REQ-013 IDLE, commit_valid=1: commit_ready=1 and rename_ready=0.
REQ-014 IDLE, commit, table entry invalid, or valid with id equal to commit_rob_id: issue write_en=1, is_ref=0, data=commit_data, and clear that entry's valid bit.
REQ-015 IDLE, commit, entry valid with id not equal to commit_rob_id (stale commit): this cycle issue the value write (is_ref=0, data=commit_data); go to FIX.
REQ-016 FIX (one cycle): issue write_en=1, is_ref=1, data=zero-extended tracked id for the latched address, which re-marks the register as pending; commit_ready=rename_ready=0; return to IDLE.
REQ-017 IDLE, rename_valid=1 with no commit: rename_ready=1; issue write_en=1, is_ref=1, data=zero-extended rename_rob_id; set the table entry valid with that id.
REQ-018 Address 0: the request is accepted (ready=1) but write_en=0 and the table is unchanged, in both the commit and rename cases.
REQ-019 flush_req=1 in any state: go to FLUSH with counter=1 and clear all table valid bits at that edge; a flush_req in FIX aborts the FIX write.
REQ-020 FLUSH: issue write_en=1, restore=1, addr=counter each cycle for 31 cycles (addr 1..31); flush_busy=1; commit_ready=rename_ready=0; after addr 31, go to IDLE.
REQ-021 flush_req received in FLUSH restarts the walk at addr 1.
REQ-022 When no write is issued, all rf_* outputs are 0.

Reset
REQ-023 While rst=1: state=IDLE, counter=0, all table valid bits=0, and every output (rf_*, readies, flush_busy) = 0.
REQ-024 rst asserted mid-FLUSH or mid-FIX abandons the operation; the block is in IDLE on the first cycle after rst deasserts.

Structure
REQ-025 The widths REG_ADDR, ROB_ADDR and DATA_BUS come from the shared bus/ROB constant headers; the state encoding stays local.
REQ-026 The tracking table is a sub-module, reg_track_table, with one set port, one clear port, a clear-all input and one lookup port.

Verification
REQ-027 Rename r5 id 3, then commit r5 id 3 -> two single-cycle writes (is_ref=1 data=3; is_ref=0 data=commit_data); r5 entry invalid.
REQ-028 Rename r5 id 3, rename r5 id 7, commit r5 id 3 data 0xAA -> writes data 0xAA is_ref=0, then next cycle is_ref=1 data=7; both readies 0 in the FIX cycle.
REQ-029 commit_valid and rename_valid in the same cycle -> only the commit write appears, rename_ready=0; the rename is accepted the next cycle.
REQ-030 flush_req pulse -> 31 restore writes to addr 1..31 on consecutive cycles, flush_busy high for exactly 31 cycles, all entries invalid; a second pulse at walk cycle 10 restarts at addr 1.
REQ-031 Rename or commit to r0 -> ready=1, write_en=0.
REQ-032 rst asserted at walk cycle 5 -> all outputs 0 during reset; IDLE after deassert.

Source files
------------

// File: rtl/reg_write_ctrl_pkg.sv
// Shared widths and helper types for the register-file write controller.
// Register, ROB and data bus widths are common to the bus and ROB blocks.
package reg_write_ctrl_pkg;

   localparam int REG_ADDR = 5;
   localparam int ROB_ADDR = 6;
   localparam int DATA_BUS = 32;
   localparam int NUM_REGS = 1 << REG_ADDR;

   typedef logic [REG_ADDR-1:0] reg_addr_t;
   typedef logic [ROB_ADDR-1:0] rob_id_t;
   typedef logic [DATA_BUS-1:0] data_t;

   typedef struct packed {
      logic      en;
      reg_addr_t addr;
      logic      restore;
      logic      is_ref;
      data_t     data;
   } rf_wr_t;

   function automatic data_t rob_to_data(input rob_id_t id);
      return data_t'(id);
   endfunction

endpackage

// File: rtl/reg_write_ctrl_track.sv
// Tracks the youngest pending rename per architectural register:
// a valid bit plus the producing ROB id, with one set, one clear and one lookup port.
module reg_track_table
   import reg_write_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      clear_all,
   input  logic      set_en,
   input  reg_addr_t set_addr,
   input  rob_id_t   set_id,
   input  logic      clr_en,
   input  reg_addr_t clr_addr,
   input  reg_addr_t lookup_addr,
   output logic      lookup_valid,
   output rob_id_t   lookup_id
);

   logic [NUM_REGS-1:0] valid_q;
   rob_id_t             id_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst || clear_all) begin
         valid_q <= '0;
      end else begin
         if (set_en) valid_q[set_addr] <= 1'b1;
         if (clr_en) valid_q[clr_addr] <= 1'b0;
      end
   end

   // Ids are only meaningful behind a valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      if (set_en) id_q[set_addr] <= set_id;
   end

   assign lookup_valid = valid_q[lookup_addr];
   assign lookup_id    = id_q[lookup_addr];

endmodule

// File: rtl/reg_write_ctrl.sv
// Arbitrates the single register-file write port between flush restore,
// commit and rename (in that priority), keeping the pending-rename table.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | serve commit, else rename
//   ST_FIX   | re-mark latched register as pending after a stale commit
//   ST_FLUSH | restore walk over addr 1..31, one register per cycle
module reg_write_ctrl
   import reg_write_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                rename_valid,
   output logic                rename_ready,
   input  logic [REG_ADDR-1:0] rename_addr,
   input  logic [ROB_ADDR-1:0] rename_rob_id,
   input  logic                commit_valid,
   output logic                commit_ready,
   input  logic [REG_ADDR-1:0] commit_addr,
   input  logic [ROB_ADDR-1:0] commit_rob_id,
   input  logic [DATA_BUS-1:0] commit_data,
   input  logic                flush_req,
   output logic                flush_busy,
   output logic                rf_write_en,
   output logic [REG_ADDR-1:0] rf_write_addr,
   output logic                rf_write_restore,
   output logic                rf_write_is_ref,
   output logic [DATA_BUS-1:0] rf_write_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIX   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0] state_q;
   reg_addr_t  walk_cnt_q;
   reg_addr_t  fix_addr_q;
   rf_wr_t     wr;
   logic       go_fix;
   logic       set_en;
   logic       clr_en;
   reg_addr_t  lookup_addr;
   logic       lookup_valid;
   rob_id_t    lookup_id;

   reg_track_table u_track (
      .clk          (clk),
      .rst          (rst),
      .clear_all    (flush_req),
      .set_en       (set_en),
      .set_addr     (rename_addr),
      .set_id       (rename_rob_id),
      .clr_en       (clr_en),
      .clr_addr     (commit_addr),
      .lookup_addr  (lookup_addr),
      .lookup_valid (lookup_valid),
      .lookup_id    (lookup_id)
   );

   always_comb begin
      wr           = '0;
      rename_ready = 1'b0;
      commit_ready = 1'b0;
      flush_busy   = 1'b0;
      go_fix       = 1'b0;
      set_en       = 1'b0;
      clr_en       = 1'b0;
      lookup_addr  = (state_q == ST_FIX) ? fix_addr_q : commit_addr;
      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               // A flush takes the port this cycle; nothing else is accepted.
               if (flush_req) begin
                  wr = '0;
               end else if (commit_valid) begin
                  commit_ready = 1'b1;
                  if (commit_addr != '0) begin
                     wr.en   = 1'b1;
                     wr.addr = commit_addr;
                     wr.data = commit_data;
                     if (lookup_valid && (lookup_id != commit_rob_id)) go_fix = 1'b1;
                     else                                              clr_en = 1'b1;
                  end
               end else if (rename_valid) begin
                  rename_ready = 1'b1;
                  if (rename_addr != '0) begin
                     wr.en     = 1'b1;
                     wr.addr   = rename_addr;
                     wr.is_ref = 1'b1;
                     wr.data   = rob_to_data(rename_rob_id);
                     set_en    = 1'b1;
                  end
               end
            end
            ST_FIX: begin
               if (!flush_req) begin
                  wr.en     = 1'b1;
                  wr.addr   = fix_addr_q;
                  wr.is_ref = 1'b1;
                  wr.data   = rob_to_data(lookup_id);
               end
            end
            ST_FLUSH: begin
               flush_busy = 1'b1;
               wr.en      = 1'b1;
               wr.addr    = walk_cnt_q;
               wr.restore = 1'b1;
            end
            default: wr = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         walk_cnt_q <= '0;
         fix_addr_q <= '0;
      end else if (flush_req) begin
         state_q    <= ST_FLUSH;
         walk_cnt_q <= reg_addr_t'(1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (go_fix) begin
                  state_q    <= ST_FIX;
                  fix_addr_q <= commit_addr;
               end
            end
            ST_FIX: state_q <= ST_IDLE;
            ST_FLUSH: begin
               if (walk_cnt_q == reg_addr_t'(NUM_REGS - 1)) begin
                  state_q    <= ST_IDLE;
                  walk_cnt_q <= '0;
               end else begin
                  walk_cnt_q <= walk_cnt_q + reg_addr_t'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rf_write_en      = wr.en;
   assign rf_write_addr    = wr.addr;
   assign rf_write_restore = wr.restore;
   assign rf_write_is_ref  = wr.is_ref;
   assign rf_write_data    = wr.data;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl: directed scenarios plus a randomized
// run, all compared against a register-level behavioural model.
module tb_reg_write_ctrl;
   import reg_write_ctrl_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   logic      rename_valid, rename_ready;
   reg_addr_t rename_addr;
   rob_id_t   rename_rob_id;
   logic      commit_valid, commit_ready;
   reg_addr_t commit_addr;
   rob_id_t   commit_rob_id;
   data_t     commit_data;
   logic      flush_req, flush_busy;
   logic      rf_write_en, rf_write_restore, rf_write_is_ref;
   reg_addr_t rf_write_addr;
   data_t     rf_write_data;

   int vectors = 0;
   int miscompares = 0;

   reg_write_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .rename_valid     (rename_valid),
      .rename_ready     (rename_ready),
      .rename_addr      (rename_addr),
      .rename_rob_id    (rename_rob_id),
      .commit_valid     (commit_valid),
      .commit_ready     (commit_ready),
      .commit_addr      (commit_addr),
      .commit_rob_id    (commit_rob_id),
      .commit_data      (commit_data),
      .flush_req        (flush_req),
      .flush_busy       (flush_busy),
      .rf_write_en      (rf_write_en),
      .rf_write_addr    (rf_write_addr),
      .rf_write_restore (rf_write_restore),
      .rf_write_is_ref  (rf_write_is_ref),
      .rf_write_data    (rf_write_data)
   );

   always #5 clk = ~clk;

   logic [42:0] got, exp_v;
   assign got = {rf_write_en, rf_write_addr, rf_write_restore, rf_write_is_ref,
                 rf_write_data, rename_ready, commit_ready, flush_busy};

   // Model: which registers await a producer, whether a re-mark is owed,
   // and the next register the restore walk will touch (0 = no walk).
   bit        m_pending [NUM_REGS];
   rob_id_t   m_owner   [NUM_REGS];
   bit        m_remark;
   reg_addr_t m_remark_reg;
   int        m_walk_next;

   function automatic logic [42:0] model_out();
      logic we = 0, rs = 0, ir = 0, rr = 0, cr = 0, bz = 0;
      reg_addr_t a = '0;
      data_t d = '0;
      if (rst) begin
      end else if (m_walk_next != 0) begin
         we = 1; rs = 1; bz = 1; a = reg_addr_t'(m_walk_next);
      end else if (m_remark) begin
         if (!flush_req) begin
            we = 1; ir = 1; a = m_remark_reg; d = data_t'(m_owner[m_remark_reg]);
         end
      end else if (flush_req) begin
      end else if (commit_valid) begin
         cr = 1;
         if (commit_addr != 0) begin we = 1; a = commit_addr; d = commit_data; end
      end else if (rename_valid) begin
         rr = 1;
         if (rename_addr != 0) begin we = 1; ir = 1; a = rename_addr; d = data_t'(rename_rob_id); end
      end
      return {we, a, rs, ir, d, rr, cr, bz};
   endfunction

   task automatic model_update();
      if (rst) begin
         m_walk_next = 0; m_remark = 0;
         foreach (m_pending[i]) m_pending[i] = 0;
      end else if (flush_req) begin
         m_walk_next = 1; m_remark = 0;
         foreach (m_pending[i]) m_pending[i] = 0;
      end else if (m_walk_next != 0) begin
         m_walk_next = (m_walk_next == NUM_REGS - 1) ? 0 : m_walk_next + 1;
      end else if (m_remark) begin
         m_remark = 0;
      end else if (commit_valid) begin
         if (commit_addr != 0) begin
            if (m_pending[commit_addr] && m_owner[commit_addr] != commit_rob_id) begin
               m_remark = 1; m_remark_reg = commit_addr;
            end else begin
               m_pending[commit_addr] = 0;
            end
         end
      end else if (rename_valid && rename_addr != 0) begin
         m_pending[rename_addr] = 1;
         m_owner[rename_addr]   = rename_rob_id;
      end
   endtask

   task automatic drive(input bit r, input bit cv, input int ca, input int cid, input data_t cd,
                        input bit rv, input int ra, input int rid, input bit fl);
      rst = r; commit_valid = cv; commit_addr = reg_addr_t'(ca); commit_rob_id = rob_id_t'(cid);
      commit_data = cd; rename_valid = rv; rename_addr = reg_addr_t'(ra);
      rename_rob_id = rob_id_t'(rid); flush_req = fl;
   endtask

   task automatic drive_idle();
      drive(0, 0, 0, 0, '0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      @(negedge clk);
      exp_v = model_out();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 5, 1, 32'h1234, 1, 6, 2, i[0]);
         settle();
         vectors++;
         if (got !== 43'd0) begin
            miscompares++; $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, got);
         end
         advance();
      end
      drive_idle();
      settle();
      vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL reset_release: got %h expected %h", got, exp_v);
      end
      advance();
   endtask

   task automatic test_rename_commit();
      drive(0, 0, 0, 0, '0, 1, 5, 3, 0);
      settle();
      vectors++;
      if (got !== exp_v || rf_write_is_ref !== 1'b1 || rf_write_data !== 32'd3 || rf_write_addr !== 5'd5) begin
         miscompares++; $display("FAIL rename_r5: got %h expected %h", got, exp_v);
      end
      advance();
      drive(0, 1, 5, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
      settle();
      vectors++;
      if (got !== exp_v || rf_write_is_ref !== 1'b0 || rf_write_data !== 32'hDEAD_BEEF) begin
         miscompares++; $display("FAIL commit_r5_match: got %h expected %h", got, exp_v);
      end
      advance();
      drive_idle();
      settle();
      vectors++;
      if (got !== exp_v || rf_write_en !== 1'b0) begin
         miscompares++; $display("FAIL no_fix_after_match: got %h expected %h", got, exp_v);
      end
      advance();
      // r5 should now be free: a commit with an unrelated id must not trigger a re-mark
      drive(0, 1, 5, 9, 32'h55, 0, 0, 0, 0);
      settle(); advance();
      drive_idle();
      settle();
      vectors++;
      if (got !== exp_v || rf_write_en !== 1'b0) begin
         miscompares++; $display("FAIL r5_entry_cleared: got %h expected %h", got, exp_v);
      end
      advance();
   endtask

   task automatic test_stale_commit();
      drive(0, 0, 0, 0, '0, 1, 5, 3, 0); settle(); advance();
      drive(0, 0, 0, 0, '0, 1, 5, 7, 0); settle(); advance();
      drive(0, 1, 5, 3, 32'hAA, 0, 0, 0, 0);
      settle();
      vectors++;
      if (got !== exp_v || rf_write_en !== 1'b1 || rf_write_is_ref !== 1'b0 || rf_write_data !== 32'hAA) begin
         miscompares++; $display("FAIL stale_value_write: got %h expected %h", got, exp_v);
      end
      advance();
      drive(0, 1, 9, 1, 32'h77, 1, 4, 2, 0);
      settle();
      vectors++;
      if (got !== exp_v || rf_write_is_ref !== 1'b1 || rf_write_data !== 32'd7 ||
          rf_write_addr !== 5'd5 || commit_ready !== 1'b0 || rename_ready !== 1'b0) begin
         miscompares++; $display("FAIL stale_fix_write: got %h expected %h", got, exp_v);
      end
      advance();
      drive_idle(); settle(); advance();
   endtask

   task automatic test_back_to_back();
      drive(0, 1, 6, 2, 32'h600D, 1, 7, 4, 0);
      settle();
      vectors++;
      if (got !== exp_v || rename_ready !== 1'b0 || rf_write_addr !== 5'd6 || rf_write_is_ref !== 1'b0) begin
         miscompares++; $display("FAIL collide_commit_wins: got %h expected %h", got, exp_v);
      end
      advance();
      drive(0, 0, 0, 0, '0, 1, 7, 4, 0);
      settle();
      vectors++;
      if (got !== exp_v || rename_ready !== 1'b1 || rf_write_addr !== 5'd7 || rf_write_data !== 32'd4) begin
         miscompares++; $display("FAIL collide_rename_next: got %h expected %h", got, exp_v);
      end
      advance();
   endtask

   task automatic test_r0();
      drive(0, 0, 0, 0, '0, 1, 0, 11, 0);
      settle();
      vectors++;
      if (got !== exp_v || rename_ready !== 1'b1 || rf_write_en !== 1'b0) begin
         miscompares++; $display("FAIL rename_r0: got %h expected %h", got, exp_v);
      end
      advance();
      drive(0, 1, 0, 11, 32'hFFFF, 0, 0, 0, 0);
      settle();
      vectors++;
      if (got !== exp_v || commit_ready !== 1'b1 || rf_write_en !== 1'b0) begin
         miscompares++; $display("FAIL commit_r0: got %h expected %h", got, exp_v);
      end
      advance();
      drive_idle(); settle();
      vectors++;
      if (got !== 43'd0) begin
         miscompares++; $display("FAIL r0_no_fix: got %h expected 0", got);
      end
      advance();
   endtask

   task automatic test_flush();
      int busy_cycles = 0;
      drive(0, 0, 0, 0, '0, 1, 5, 3, 0); settle(); advance();
      drive(0, 0, 0, 0, '0, 0, 0, 0, 1);
      settle();
      vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL flush_pulse_cycle: got %h expected %h", got, exp_v);
      end
      advance();
      for (int i = 1; i < NUM_REGS; i++) begin
         drive_idle(); settle();
         if (flush_busy === 1'b1) busy_cycles++;
         vectors++;
         if (got !== exp_v || rf_write_addr !== reg_addr_t'(i) || rf_write_restore !== 1'b1) begin
            miscompares++; $display("FAIL walk_addr%0d: got %h expected %h", i, got, exp_v);
         end
         advance();
      end
      drive(0, 1, 5, 9, 32'h1, 0, 0, 0, 0); settle();
      vectors++;
      if (got !== exp_v || flush_busy !== 1'b0 || busy_cycles != 31) begin
         miscompares++; $display("FAIL walk_end: got %h busy_cycles %0d expected %h busy_cycles 31", got, busy_cycles, exp_v);
      end
      advance();
      drive_idle(); settle();
      vectors++;
      if (got !== exp_v || rf_write_en !== 1'b0) begin
         miscompares++; $display("FAIL flush_cleared_table: got %h expected %h", got, exp_v);
      end
      advance();
      // second pulse mid-walk restarts from addr 1
      drive(0, 0, 0, 0, '0, 0, 0, 0, 1); settle(); advance();
      for (int i = 1; i <= 10; i++) begin
         drive(0, 0, 0, 0, '0, 0, 0, 0, i == 10); settle();
         vectors++;
         if (got !== exp_v || rf_write_addr !== reg_addr_t'(i)) begin
            miscompares++; $display("FAIL rewalk_pre%0d: got %h expected %h", i, got, exp_v);
         end
         advance();
      end
      for (int i = 1; i < NUM_REGS; i++) begin
         drive_idle(); settle();
         vectors++;
         if (got !== exp_v || rf_write_addr !== reg_addr_t'(i) || flush_busy !== 1'b1) begin
            miscompares++; $display("FAIL rewalk_addr%0d: got %h expected %h", i, got, exp_v);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_walk();
      drive(0, 0, 0, 0, '0, 0, 0, 0, 1); settle(); advance();
      for (int i = 1; i < 5; i++) begin drive_idle(); settle(); advance(); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, '0, 0, 0, 0, 0); settle();
         vectors++;
         if (got !== 43'd0) begin
            miscompares++; $display("FAIL rst_mid_walk%0d: got %h expected 0", i, got);
         end
         advance();
      end
      drive(0, 0, 0, 0, '0, 1, 3, 8, 0); settle();
      vectors++;
      if (got !== exp_v || flush_busy !== 1'b0 || rename_ready !== 1'b1 || rf_write_addr !== 5'd3) begin
         miscompares++; $display("FAIL idle_after_rst: got %h expected %h", got, exp_v);
      end
      advance();
   endtask

   task automatic test_random();
      for (int n = 0; n < 2000; n++) begin
         int ca = $urandom_range(0, 7);
         int cid = ($urandom_range(0, 1) == 1) ? int'(m_owner[ca]) : int'($urandom_range(0, 63));
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, ca, cid, data_t'($urandom()),
               $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 63),
               $urandom_range(0, 59) == 0);
         settle();
         vectors++;
         if (got !== exp_v) begin
            miscompares++; $display("FAIL random_cyc%0d: got %h expected %h", n, got, exp_v);
         end
         advance();
      end
   endtask

   initial begin
      m_walk_next = 0; m_remark = 0; m_remark_reg = '0;
      foreach (m_pending[i]) begin m_pending[i] = 0; m_owner[i] = '0; end
      drive(1, 0, 0, 0, '0, 0, 0, 0, 0);
      #1;
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_back_to_back();
      test_r0();
      test_flush();
      test_reset_mid_walk();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
